mem_access_unit: RTL and testbench

Memory-side responder for the multicycle CPU's control unit: accepts one load/store request at a time over a req/done handshake, performs word, halfword or byte accesses against the 32-bit word-addressed synchronous memory, and returns zero-extended load data. Sub-word stores are done as read-modify-write so the memory only ever sees full-word writes. Sits between the control unit / A-B registers and the memory block, replacing fixed wait counts in the control FSM with a done pulse.

---
 rtl/mem_access_pkg.sv | 11 +
 rtl/lane_unit.sv | 18 +
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings and defaults for the memory access unit
package mem_access_pkg;
  localparam int MEM_LATENCY_DEF = 2;
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_e;
endpackage

// File: rtl/lane_unit.sv
// lane_unit: little-endian lane extraction (zero-extended) and sub-word merge
module lane_unit import mem_access_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] extract,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] m;
  always_comb begin
    sh = size == SZ_BYTE ? {addr, 3'b000} : size == SZ_HALF ? {addr[1], 4'b0000} : 5'd0;
    m = size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    extract = (word >> sh) & m;
    merged = (word & ~(m << sh)) | ((wdata & m) << sh);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: req/done load/store responder with read-modify-write sub-word stores
module mem_access_unit import mem_access_pkg::*; #(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we_req,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY + 1) : 1;
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d, mem_wr_q, mem_wr_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] extract, merged;
  logic        bad;
  lane_unit u_lane (
    .word(mem_rdata),
    .addr(off_q),
    .size(size_q),
    .wdata(wdata_q),
    .extract(extract),
    .merged(merged)
  );
  assign bad = size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && |addr[1:0]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    size_d = size_q;
    off_d = off_q;
    wdata_d = wdata_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    rdata_d = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_wr_d = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (req) begin
        we_d = we_req;
        size_d = size;
        off_d = addr[1:0];
        wdata_d = wdata;
        mem_addr_d = {addr[31:2], 2'b00};
        busy_d = 1'b1;
        if (bad) begin
          state_d = DONE;
          done_d = 1'b1;
          err_d = 1'b1;
        end else if (we_req && size == SZ_WORD) begin
          state_d = WRITE;
          mem_wr_d = 1'b1;
          mem_wdata_d = wdata;
        end else begin
          state_d = RD_WAIT;
          cnt_d = CW'(MEM_LATENCY - 1);
        end
      end
      RD_WAIT: if (|cnt_q) cnt_d = cnt_q - CW'(1);
      else if (we_q) begin
        state_d = WRITE;
        mem_wr_d = 1'b1;
        mem_wdata_d = merged;
      end else begin
        state_d = DONE;
        done_d = 1'b1;
        rdata_d = extract;
      end
      WRITE: begin
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      size_q <= 2'b00;
      off_q <= 2'b00;
      wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      mem_addr_q <= '0;
      mem_wr_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      size_q <= size_d;
      off_q <= off_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_wr = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of latency, lane handling, errors and reset abort
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0, we_req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        busy, done, err, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem [0:255];
  int          n_chk = 0, n_fail = 0;
  int          lat, wrs, cnt;
  logic [31:0] wd, ma;
  logic        e;
  mem_access_unit #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we_req(we_req), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  // data is registered once after the address, so it is settled well before a 2-cycle capture
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic poke);
    @(negedge clk);
    req = 1'b1; we_req = w; size = sz; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we_req = 1'b0; size = 2'b11; addr = '0; wdata = '1;
    lat = 0; wrs = 0; wd = '0; e = 1'b0; ma = mem_addr;
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      if (poke && j == 1) begin req = 1'b1; size = 2'b00; addr = a ^ 32'h4; end
      if (poke && j == 2) req = 1'b0;
      if (mem_wr) begin wrs++; wd = mem_wdata; end
      if (done) begin lat = j; e = err; end
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h4433_2211;
    mem[8'h41] = 32'h8877_6655;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wr", {31'b0, mem_wr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); reset = 1'b0;
    run(1'b0, 2'b00, 32'h100, 0, 1'b0);
    check("ldw_lat", lat, 3); check("ldw_rdata", rdata, 32'h4433_2211);
    check("ldw_err", {31'b0, e}, 0); check("ldw_wr", wrs, 0); check("ldw_addr", ma, 32'h100);
    run(1'b0, 2'b10, 32'h103, 0, 1'b0);
    check("ldb_rdata", rdata, 32'h0000_0044); check("ldb_lat", lat, 3);
    run(1'b0, 2'b01, 32'h102, 0, 1'b0);
    check("ldh_rdata", rdata, 32'h0000_4433);
    run(1'b1, 2'b10, 32'h101, 32'hFFFF_FFAB, 1'b0);
    check("stb_lat", lat, 4); check("stb_wr", wrs, 1); check("stb_wdata", wd, 32'h4433_AB11);
    check("stb_err", {31'b0, e}, 0);
    run(1'b0, 2'b00, 32'h100, 0, 1'b0);
    check("stb_readback", rdata, 32'h4433_AB11);
    run(1'b1, 2'b00, 32'h100, 32'hDEAD_BEEF, 1'b0);
    check("stw_lat", lat, 2); check("stw_wr", wrs, 1); check("stw_wdata", wd, 32'hDEAD_BEEF);
    run(1'b0, 2'b10, 32'h102, 0, 1'b0);
    check("stw_readback", rdata, 32'h0000_00AD);
    run(1'b0, 2'b01, 32'h101, 0, 1'b0);
    check("mis_lat", lat, 1); check("mis_err", {31'b0, e}, 1); check("mis_wr", wrs, 0);
    check("mis_rdata", rdata, 32'h0000_00AD);
    run(1'b0, 2'b11, 32'h100, 0, 1'b0);
    check("rsv_lat", lat, 1); check("rsv_err", {31'b0, e}, 1); check("rsv_rdata", rdata, 32'h0000_00AD);
    run(1'b1, 2'b00, 32'h102, 32'h1234_5678, 1'b0);
    check("misw_err", {31'b0, e}, 1); check("misw_wr", wrs, 0);
    run(1'b0, 2'b00, 32'h104, 0, 1'b1);
    check("ign_lat", lat, 3); check("ign_rdata", rdata, 32'h8877_6655); check("ign_addr", ma, 32'h104);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (done) cnt++; end
    check("ign_extra_done", cnt, 0);
    @(negedge clk);
    req = 1'b1; we_req = 1'b1; size = 2'b10; addr = 32'h104; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    check("rmw_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_err", {31'b0, err}, 0);
    check("abort_rdata", rdata, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wr", {31'b0, mem_wr}, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (done || mem_wr) cnt++; end
    check("abort_quiet", cnt, 0);
    run(1'b0, 2'b00, 32'h104, 0, 1'b0);
    check("post_lat", lat, 3); check("post_rdata", rdata, 32'h8877_6655);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
